// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional halt-opcode feature is selected with the FETCH_HALT_EN macro.
package fetch_pkg;

  localparam int N_DEF      = 8;
  localparam int ADDR_W_DEF = 5;

  localparam logic [N_DEF-1:0] HALT_OPCODE = {N_DEF{1'b1}};

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4,
    S_HALT    = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: synchronous active-low clear, branch load, increment with wrap.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r;

  // PC update; a branch load takes priority over the increment
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      pc_r <= load_addr;
    end else if (inc) begin
      pc_r <= pc_r + PC_ONE;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads a synchronous ROM and hands instructions to the decoder
// over a valid/ready handshake. Define FETCH_HALT_EN to stop on the all-ones opcode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int n      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              run,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [n-1:0]      rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic              rom_init,
  output logic [n-1:0]      ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halt
);

  fetch_state_t      state_r;
  fetch_state_t      state_next_s;
  logic [n-1:0]      ir_r;
  logic              ir_valid_r;
  logic [ADDR_W-1:0] pc_s;
  logic              handshake_s;
  logic              pc_load_s;
  logic              pc_inc_s;

  assign handshake_s = (state_r == S_HOLD) && ir_valid_r && ir_ready;
  assign pc_load_s   = branch_en && ((state_r == S_IDLE) || handshake_s);
  assign pc_inc_s    = (state_r == S_CAPTURE);

`ifdef FETCH_HALT_EN
  localparam logic [n-1:0] HALT_CODE = {n{1'b1}};
  logic is_halt_s;
  assign is_halt_s = (ir_r == HALT_CODE);
`endif

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_fetch_pc (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (pc_load_s),
    .load_addr (branch_addr),
    .inc       (pc_inc_s),
    .pc        (pc_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; once started, a fetch always runs through to HOLD
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_INIT: begin
        state_next_s = S_IDLE;
      end
      S_IDLE: begin
        if (run) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_next_s = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_next_s = S_HOLD;
      end
      S_HOLD: begin
        if (handshake_s) begin
`ifdef FETCH_HALT_EN
          if (is_halt_s) begin
            state_next_s = S_HALT;
          end else if (run) begin
            state_next_s = S_ISSUE;
          end else begin
            state_next_s = S_IDLE;
          end
`else
          if (run) begin
            state_next_s = S_ISSUE;
          end else begin
            state_next_s = S_IDLE;
          end
`endif
        end else begin
          state_next_s = S_HOLD;
        end
      end
      S_HALT: begin
        state_next_s = S_HALT;
      end
      default: begin
        state_next_s = S_INIT;
      end
    endcase
  end

  // Instruction register: loaded from ROM in CAPTURE, held until the handshake
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      ir_r       <= {n{1'b0}};
      ir_valid_r <= 1'b0;
    end else if (state_r == S_CAPTURE) begin
      ir_r       <= rom_q;
      ir_valid_r <= 1'b1;
    end else if (handshake_s) begin
      ir_r       <= ir_r;
      ir_valid_r <= 1'b0;
    end else begin
      ir_r       <= ir_r;
      ir_valid_r <= ir_valid_r;
    end
  end

  assign rom_addr = pc_s;
  assign pc       = pc_s;
  assign rom_we   = 1'b0;
  assign rom_init = (state_r == S_INIT);
  assign ir       = ir_r;
  assign ir_valid = ir_valid_r;

`ifdef FETCH_HALT_EN
  assign halt = (state_r == S_HALT);
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a cycle table for reset and streaming,
// then directed sequences for backpressure, wrap/branch, halt and mid-fetch reset.
module tb_instr_fetch;

  localparam int N  = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          run;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic [N-1:0]  rom_q;
  logic [AW-1:0] rom_addr;
  logic          rom_we;
  logic          rom_init;
  logic [N-1:0]  ir;
  logic          ir_valid;
  logic          ir_ready;
  logic [AW-1:0] pc;
  logic          halt;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] rom_mem [0:31];

  always #5 clk = ~clk;

  // Synchronous-read ROM model
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  instr_fetch #(.n(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .run         (run),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .rom_q       (rom_q),
    .rom_addr    (rom_addr),
    .rom_we      (rom_we),
    .rom_init    (rom_init),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .pc          (pc),
    .halt        (halt)
  );

  typedef struct packed {
    logic          clear_n;
    logic          run;
    logic          ir_ready;
    logic          rom_init;
    logic [AW-1:0] pc;
    logic          ir_valid;
    logic [N-1:0]  ir;
  } vec_t;

  vec_t vecs [0:13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    clear_n   = 1'b0;
    run       = 1'b0;
    branch_en = 1'b0;
    ir_ready  = 1'b0;
    step();
    chk("rst_init_in_reset", {31'd0, rom_init}, 32'd1);
    chk("rst_halt_clear", {31'd0, halt}, 32'd0);
    step();
    clear_n = 1'b1;
    chk("rst_init_after_release", {31'd0, rom_init}, 32'd1);
    step();
    chk("rst_init_one_cycle", {31'd0, rom_init}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
  endtask

  initial begin
    logic [21:0] got;
    logic [21:0] exp;
    logic        seen;

    for (int i = 0; i < 32; i++) rom_mem[i] = 8'hA0 + 8'(i);
    rom_mem[0] = 8'h11;
    rom_mem[1] = 8'h22;
    rom_mem[2] = 8'h33;
    rom_mem[3] = 8'hFF;
    rom_mem[4] = 8'h44;

    clear_n     = 1'b0;
    run         = 1'b0;
    branch_en   = 1'b0;
    branch_addr = 5'd0;
    ir_ready    = 1'b0;

    //            clr   run   rdy   init  pc     vld   ir
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 8'h11};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 8'h11};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 8'h22};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 8'h22};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 8'h22};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 8'h33};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 8'h33};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 8'h33};

    // Reset and streaming trace, one row per clock
    for (int i = 0; i < 14; i++) begin
      clear_n  = vecs[i].clear_n;
      run      = vecs[i].run;
      ir_ready = vecs[i].ir_ready;
      step();
      got = {rom_init, rom_we, halt, ir_valid, rom_addr, pc, ir};
      exp = {vecs[i].rom_init, 1'b0, 1'b0, vecs[i].ir_valid, vecs[i].pc, vecs[i].pc, vecs[i].ir};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got init/we/halt/vld/addr/pc/ir=%h expected %h", i, got, exp);
      end
    end

    // Backpressure: decoder stalls for five cycles
    do_reset();
    run = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = ir_valid;
    end
    chk("bp_valid_seen", {31'd0, seen}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_stall", {ir_valid, ir, rom_addr, pc}, {1'b1, 8'h11, 5'd1, 5'd1});
    end
    ir_ready = 1'b1;
    step();
    chk("bp_release", {ir_valid, rom_addr}, {1'b0, 5'd1});
    ir_ready = 1'b0;
    step();
    step();
    chk("bp_next_fetch", {ir_valid, ir, pc}, {1'b1, 8'h22, 5'd2});

    // Wrap at 31 and branch on the handshake
    do_reset();
    branch_en   = 1'b1;
    branch_addr = 5'd31;
    step();
    chk("br_idle_load", {27'd0, pc}, 32'd31);
    branch_en = 1'b0;
    run       = 1'b1;
    step();
    step();
    step();
    chk("wrap_fetch", {ir_valid, ir, pc}, {1'b1, 8'hBF, 5'd0});
    branch_en   = 1'b1;
    branch_addr = 5'd20;
    ir_ready    = 1'b1;
    step();
    chk("br_hold_load", {ir_valid, rom_addr, pc}, {1'b0, 5'd20, 5'd20});
    branch_addr = 5'd7;
    ir_ready    = 1'b0;
    step();
    chk("br_ignored_issue", {27'd0, pc}, 32'd20);
    step();
    chk("br_fetch_target", {ir_valid, ir, pc}, {1'b1, 8'hB4, 5'd21});
    step();
    chk("br_ignored_stall", {ir_valid, pc}, {1'b1, 5'd21});

    // run dropped mid-fetch still completes the instruction
    branch_en = 1'b0;
    run       = 1'b0;
    ir_ready  = 1'b1;
    step();
    ir_ready = 1'b0;
    run      = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    chk("run_drop_complete", {ir_valid, ir, pc}, {1'b1, 8'hB5, 5'd22});

    // Halt opcode at address 3
    do_reset();
    run      = 1'b1;
    ir_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("halt_op_delivered", {halt, ir_valid, ir, pc}, {1'b0, 1'b1, 8'hFF, 5'd4});
    step();
`ifdef FETCH_HALT_EN
    chk("halt_set", {halt, ir_valid, ir, pc}, {1'b1, 1'b0, 8'hFF, 5'd4});
    for (int k = 0; k < 6; k++) begin
      step();
      chk("halt_stays", {halt, ir_valid, pc}, {1'b1, 1'b0, 5'd4});
    end
`else
    chk("nohalt_cont", {halt, ir_valid}, {1'b0, 1'b0});
    step();
    step();
    chk("nohalt_next", {halt, ir_valid, ir, pc}, {1'b0, 1'b1, 8'h44, 5'd5});
`endif
    do_reset();
    chk("halt_cleared", {31'd0, halt}, 32'd0);

    // Reset asserted while in CAPTURE
    run = 1'b1;
    step();
    step();
    clear_n = 1'b0;
    step();
    chk("midreset", {rom_init, ir_valid, pc}, {1'b1, 1'b0, 5'd0});
    clear_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
